// File: rtl/ckong_dl_if.sv
// Download bus between hps_io (ioctl_* side) and the ROM write side of the Crazy Kong core.
// The master drives the ioctl byte stream; the slave returns registered ROM writes.
interface ckong_dl_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        cpu_we;
  logic        gfx_we;
  logic        snd_we;
  logic        prom_we;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_addr, rom_data, cpu_we, gfx_we, snd_we, prom_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_addr, rom_data, cpu_we, gfx_we, snd_we, prom_we
  );
endinterface

// File: rtl/ckong_dl_ctrl.sv
// Boot ROM download sequencer for Crazy Kong: decodes ioctl bytes into region strobes,
// keeps a running checksum and stretches core reset after loads and user resets.
module ckong_dl_ctrl #(
  parameter logic [16:0] CPU_END     = 17'h06000,
  parameter logic [16:0] GFX_END     = 17'h0A000,
  parameter logic [16:0] SND_END     = 17'h0C000,
  parameter logic [16:0] PROM_END    = 17'h0C100,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  ckong_dl_if.slave   bus,
  input  logic        user_reset,
  output logic        core_reset,
  output logic        loaded,
  output logic        err_overflow,
  output logic [15:0] checksum
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_reset_q, core_reset_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic [15:0]      cksum_q, cksum_d;
  logic [16:0]      rom_addr_q, rom_addr_d;
  logic [7:0]       rom_data_q, rom_data_d;
  logic [3:0]       we_q, we_d;
  logic             wr_ok;
  logic             in_range;
  logic [16:0]      low_addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    cksum_d    = cksum_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    we_d       = 4'b0000;
    low_addr   = bus.ioctl_addr[16:0];
    wr_ok      = (state_q == LOAD) && bus.ioctl_wr && bus.ioctl_download;
    in_range   = (bus.ioctl_addr[24:17] == 8'h00) && (low_addr < PROM_END);

    // A new download always wins over user reset, from HOLD as well as RUN.
    case (state_q)
      IDLE: begin
        if (bus.ioctl_download) state_d = LOAD;
      end
      LOAD: begin
        if (!bus.ioctl_download) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end else if (user_reset) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.ioctl_download) begin
          state_d = LOAD;
        end else if (user_reset) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == LOAD && state_q != LOAD) begin
      cksum_d  = 16'h0000;
      err_d    = 1'b0;
      loaded_d = 1'b0;
    end
    if (state_d == RUN && state_q != RUN) loaded_d = 1'b1;

    // Out-of-range bytes raise the sticky error and are kept out of the checksum.
    if (wr_ok) begin
      if (in_range) begin
        rom_addr_d = low_addr;
        rom_data_d = bus.ioctl_dout;
        cksum_d    = cksum_q + {8'h00, bus.ioctl_dout};
        if (low_addr < CPU_END)      we_d = 4'b0001;
        else if (low_addr < GFX_END) we_d = 4'b0010;
        else if (low_addr < SND_END) we_d = 4'b0100;
        else                         we_d = 4'b1000;
      end else begin
        err_d = 1'b1;
      end
    end

    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      cksum_q      <= 16'h0000;
      rom_addr_q   <= 17'h00000;
      rom_data_q   <= 8'h00;
      we_q         <= 4'b0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      cksum_q      <= cksum_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      we_q         <= we_d;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;
  assign bus.cpu_we   = we_q[0];
  assign bus.gfx_we   = we_q[1];
  assign bus.snd_we   = we_q[2];
  assign bus.prom_we  = we_q[3];
  assign core_reset   = core_reset_q;
  assign loaded       = loaded_q;
  assign err_overflow = err_q;
  assign checksum     = cksum_q;

endmodule

// File: doc/ckong_dl_ctrl.md
# ckong_dl_ctrl

Sequences the boot-time ROM download stream from hps_io into the Crazy Kong core's ROM regions. It decodes each download byte to one of four region write strobes and keeps a running checksum. It holds the core in reset while loading and for a fixed stretch afterwards, and applies user resets through the same reset-hold path. It sits between hps_io (ioctl_*) and ckong (dn_*/reset) in the emu top level.

## Interface
- CPU_END, 17'h06000, exclusive end of CPU program ROM region (starts at 0)
- GFX_END, 17'h0A000, exclusive end of graphics ROM region (starts at CPU_END)
- SND_END, 17'h0C000, exclusive end of sound ROM region (starts at GFX_END)
- PROM_END, 17'h0C100, exclusive end of colour PROM region (starts at SND_END)
- HOLD_CYCLES, 1024, core reset stretch in clk_sys cycles after load or user reset (≥2)

Ports:
- clk_sys  in  1  system clock; sole clock
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- user_reset  in  1  level; OSD/button reset request
- rom_addr  out  17  registered write address (region-relative not applied; absolute)
- rom_data  out  8  registered write data
- cpu_we, gfx_we, snd_we, prom_we  out  1 each  one-cycle region write strobes
- core_reset  out  1  reset to ckong
- loaded  out  1  a download completed and core released
- err_overflow  out  1  sticky: byte addressed at ≥PROM_END or addr[24:17]≠0
- checksum  out  16  mod-2^16 sum of bytes accepted in current download

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- IDLE (reset state): core_reset=1. Goes to LOAD when ioctl_download=1.
- LOAD: on entry cycle, checksum←0 and err_overflow←0. Each ioctl_wr with ioctl_download=1 is decoded as follows:
  - addr<CPU_END → cpu_we.
  - <GFX_END → gfx_we.
  - <SND_END → snd_we.
  - <PROM_END → prom_we.
  - Otherwise no strobe, err_overflow←1, byte excluded from checksum.
- LOAD: an accepted byte adds ioctl_dout, zero-extended, to checksum with wraparound.
- LOAD: ioctl_download falling → HOLD, counter←0.
- HOLD: core_reset=1. Counter increments each cycle. At counter=HOLD_CYCLES-1 → RUN. user_reset=1 holds counter at 0.
- RUN: core_reset=0, loaded=1.
  - user_reset=1 → HOLD, counter←0, loaded stays 1.
  - ioctl_download=1 → LOAD, loaded←0.
- ioctl_download rising in HOLD also → LOAD. It takes priority over user_reset.
- ioctl_wr outside LOAD is ignored.
- Write strobes are only asserted in LOAD or on the cycle after leaving it (pipeline drain).

## Timing
- Reset values:
  - State IDLE, core_reset=1.
  - loaded=0, err_overflow=0, checksum=0.
  - rom_addr=0, rom_data=0, all *_we=0.
  - Counter=0.
- Write latency: ioctl_wr at cycle N → rom_addr/rom_data/*_we valid at N+1 for exactly one cycle. Back-to-back ioctl_wr every cycle is supported with no drops.
- At most one *_we is high in any cycle.
- checksum reflects byte N at cycle N+1.
- A final ioctl_wr coinciding with the ioctl_download fall cycle is dropped (gated by ioctl_download). A write on the cycle before the fall is still strobed at N+1, during HOLD.
- core_reset deasserts exactly HOLD_CYCLES cycles after the first HOLD cycle (user_reset low throughout).
- Reset mid-download: all outputs return to reset values on the next edge. No strobe is issued for a pending byte. State IDLE waits for ioctl_download, and an already-high ioctl_download enters LOAD on the next cycle.
- The counter width covers HOLD_CYCLES-1 with no wraparound.

## Test plan
- Full load: download bytes 0x01 at 0x00000, 0x02 at 0x06000, 0x03 at 0x0A000, 0x04 at 0x0C000, then drop download.
  - Required: one cycle each of cpu_we, gfx_we, snd_we, prom_we, with matching rom_addr/rom_data, each one cycle after its ioctl_wr.
  - Required: checksum=0x000A, err_overflow=0.
  - Required: core_reset low exactly 1024 cycles after HOLD entry, then loaded=1.
- Back-to-back: 256 consecutive-cycle writes of 0xFF at 0x05F80–0x0607F.
  - Required: 128 cpu_we followed by 128 gfx_we with no gap.
  - Required: checksum=0xFF00.
- Overflow: write 0x55 at 0x0C100 and 0x66 at 0x20000.
  - Required: no strobes, err_overflow=1, checksum unchanged.
  - Required: err_overflow is cleared at the next download start.
- User reset in RUN: assert user_reset for 10 cycles.
  - Required: core_reset=1 from the next cycle, and stays 1 until 1024 cycles after user_reset falls.
  - Required: loaded stays 1.
- Reset mid-download: assert reset while ioctl_wr is pulsing.
  - Required: next cycle has all *_we=0, core_reset=1, checksum=0, loaded=0.
  - Required: a subsequent download completes normally.
- Re-download in HOLD: raise ioctl_download at HOLD cycle 500.
  - Required: state is LOAD, checksum cleared, core_reset stays 1 with no glitch.
